dt_walk_ctrl: RTL and testbench

//  Sequential decision-tree evaluator: a single shared comparator walked over a writable node table, one node per cycle.

---
 rtl/dt_walk_ctrl.sv | 155 +++++++++++++++
 tb/tb_dt_walk_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_walk_ctrl.sv
// Sequential decision-tree evaluator: one shared comparator walks a writable node table, one node per clock.
// Optional macro DT_DEPTH_GUARD_EN adds a depth counter that aborts runaway walks with err_out=1.
module dt_walk_ctrl #(
  parameter int N_FEAT    = 7,
  parameter int FEAT_W    = 6,
  parameter int FIDX_W    = 3,
  parameter int NODE_AW   = 4,
  parameter int CLASS_W   = 8,
  parameter int MAX_DEPTH = 15,
  localparam int NODE_W   = 1 + FIDX_W + FEAT_W + NODE_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] feat_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       class_out,
  output logic                     err_out
);

  localparam int N_NODES = 2 ** NODE_AW;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and class_out is stable while out_valid waits.
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                     state_q, state_d;
  logic [NODE_AW-1:0]         ptr_q, ptr_d;
  logic [N_FEAT*FEAT_W-1:0]   feat_q, feat_d;
  logic [CLASS_W-1:0]         class_q, class_d;
  logic                       cfg_err_q, cfg_err_d;

  logic [NODE_W-1:0]          node_tab [N_NODES];
  logic [NODE_W-1:0]          node;
  logic                       node_leaf;
  logic [FIDX_W-1:0]          node_fidx;
  logic [FEAT_W-1:0]          node_thr;
  logic [NODE_AW-1:0]         node_rptr;
  logic [FEAT_W-1:0]          fval;
  logic                       go_left;

`ifdef DT_DEPTH_GUARD_EN
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  logic [DEPTH_W-1:0]         depth_q, depth_d;
  logic                       err_q, err_d;
`endif

  // Table is deliberately not reset so a reset mid-walk keeps the loaded tree.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == IDLE)) node_tab[cfg_addr] <= cfg_data;
  end

  assign node      = node_tab[ptr_q];
  assign node_leaf = node[NODE_W-1];
  assign node_fidx = node[NODE_W-2 -: FIDX_W];
  assign node_thr  = node[NODE_AW +: FEAT_W];
  assign node_rptr = node[NODE_AW-1:0];

  // Indices past the last feature read as zero.
  always_comb begin
    fval = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (node_fidx == FIDX_W'(i)) fval = feat_q[i*FEAT_W +: FEAT_W];
    end
  end

  assign go_left = (fval <= node_thr);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    feat_d    = feat_q;
    class_d   = class_q;
    cfg_err_d = cfg_we && (state_q != IDLE);
`ifdef DT_DEPTH_GUARD_EN
    depth_d   = depth_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          feat_d  = feat_in;
          ptr_d   = '0;
          state_d = WALK;
`ifdef DT_DEPTH_GUARD_EN
          depth_d = '0;
`endif
        end
      end
      WALK: begin
        if (node_leaf) begin
          class_d = node[CLASS_W-1:0];
          state_d = DONE;
`ifdef DT_DEPTH_GUARD_EN
          err_d   = 1'b0;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
`endif
        end else begin
          ptr_d = go_left ? (ptr_q + NODE_AW'(1)) : node_rptr;
`ifdef DT_DEPTH_GUARD_EN
          depth_d = depth_q + DEPTH_W'(1);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      feat_q    <= '0;
      class_q   <= '0;
      cfg_err_q <= 1'b0;
`ifdef DT_DEPTH_GUARD_EN
      depth_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      feat_q    <= feat_d;
      class_q   <= class_d;
      cfg_err_q <= cfg_err_d;
`ifdef DT_DEPTH_GUARD_EN
      depth_q   <= depth_d;
      err_q     <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign class_out = class_q;
  assign cfg_err   = cfg_err_q;
`ifdef DT_DEPTH_GUARD_EN
  assign err_out   = err_q;
`else
  assign err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_dt_walk_ctrl.sv
// Self-checking bench for dt_walk_ctrl: directed scenarios plus random acyclic trees,
// each result checked against a loop-based tree-walk model over a shadow copy of the table.
module tb_dt_walk_ctrl;

  localparam int N_FEAT = 7, FEAT_W = 6, FIDX_W = 3, NODE_AW = 4, CLASS_W = 8, MAX_DEPTH = 15;
  localparam int NODE_W = 1 + FIDX_W + FEAT_W + NODE_AW;
`ifdef DT_DEPTH_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_we = 1'b0;
  logic [NODE_AW-1:0]       cfg_addr = '0;
  logic [NODE_W-1:0]        cfg_data = '0;
  logic                     cfg_err;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] feat_in = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [CLASS_W-1:0]       class_out;
  logic                     err_out;

  int total = 0;
  int bad = 0;
  int tab [16];

  dt_walk_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .feat_in(feat_in),
    .out_valid(out_valid), .out_ready(out_ready), .class_out(class_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  function automatic int mk_int(int fidx, int thr, int rptr);
    return fidx * 1024 + thr * 16 + rptr;
  endfunction

  function automatic int mk_leaf(int cls);
    return 8192 + cls;
  endfunction

  // Walk the shadow table the way the node format describes it.
  function automatic void model(input logic [N_FEAT*FEAT_W-1:0] f, output int cls, output int err,
                                output int d, output bit hang);
    int p = 0;
    cls = 0; err = 0; d = 0; hang = 1'b1;
    for (int steps = 0; steps < 200; steps++) begin
      int w = tab[p];
      int fi = (w / 1024) % 8;
      int thr = (w / 16) % 64;
      int rp = w % 16;
      int fv = 0;
      if ((w / 8192) % 2 == 1) begin
        cls = w % 256; hang = 1'b0; return;
      end
      if (GUARD && d == MAX_DEPTH) begin
        cls = 0; err = 1; hang = 1'b0; return;
      end
      if (fi < N_FEAT) fv = int'((f >> (fi * FEAT_W)) & 42'h3f);
      p = (fv <= thr) ? (p + 1) % 16 : rp;
      d++;
    end
  endfunction

  function automatic logic [N_FEAT*FEAT_W-1:0] rand_feat();
    logic [N_FEAT*FEAT_W-1:0] f;
    f[31:0] = $urandom;
    f[41:32] = 10'($urandom);
    return f;
  endfunction

  task automatic write_node(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = NODE_AW'(addr); cfg_data = NODE_W'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    tab[addr] = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Accept one vector, check latency/class/err against the model (and an optional fixed class).
  task automatic run_walk(input logic [N_FEAT*FEAT_W-1:0] f, input int want_cls, input string name);
    int mcls, merr, md, cyc;
    bit hang;
    model(f, mcls, merr, md, hang);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; feat_in = f;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc);
    total++;
    if (cyc != md + 2 || out_valid !== 1'b1) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, md + 2);
    end
    total++;
    if (class_out !== CLASS_W'(mcls)) begin
      bad++; $display("FAIL %s class: got %0d want %0d", name, class_out, mcls);
    end
    total++;
    if (err_out !== 1'(merr)) begin
      bad++; $display("FAIL %s err: got %b want %0d", name, err_out, merr);
    end
    if (want_cls >= 0) begin
      total++;
      if (class_out !== CLASS_W'(want_cls)) begin
        bad++; $display("FAIL %s fixed class: got %0d want %0d", name, class_out, want_cls);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  function automatic logic [N_FEAT*FEAT_W-1:0] with_f6(input int v);
    logic [N_FEAT*FEAT_W-1:0] f = rand_feat();
    f[6*FEAT_W +: FEAT_W] = FEAT_W'(v);
    return f;
  endfunction

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++;
    if (class_out !== 8'd0 || err_out !== 1'b0 || cfg_err !== 1'b0) begin
      bad++; $display("FAIL reset outputs: class=%0d err=%b cfg_err=%b want 0/0/0", class_out, err_out, cfg_err);
    end
  endtask

  task automatic load_small();
    write_node(0, mk_int(6, 2, 2));
    write_node(1, mk_leaf(165));
    write_node(2, mk_leaf(25));
  endtask

  task automatic test_small_tree();
    load_small();
    run_walk(with_f6(2), 165, "f6_2");
    run_walk(with_f6(3), 25, "f6_3");
    run_walk(with_f6(63), 25, "f6_63");
    run_walk(with_f6(0), 165, "f6_0");
  endtask

  task automatic test_backpressure();
    int cyc;
    in_valid = 1'b1; feat_in = with_f6(3);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; feat_in = with_f6(2);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || class_out !== 8'd25 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold[%0d]: out_valid=%b class=%0d in_ready=%b want 1/25/0", i, out_valid, class_out, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    run_walk(with_f6(2), 165, "after_hold");
  endtask

  task automatic test_cfg_busy();
    int cyc;
    in_valid = 1'b1; feat_in = with_f6(2);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = NODE_W'(mk_leaf(99));
    @(negedge clk);
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== 1'b1) begin
      bad++; $display("FAIL cfg_err pulse: got %b want 1", cfg_err);
    end
    wait_out(cyc);
    total++;
    if (cfg_err !== 1'b0 || class_out !== 8'd165) begin
      bad++; $display("FAIL busy write: cfg_err=%b class=%0d want 0/165", cfg_err, class_out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run_walk(with_f6(2), 165, "table_kept");
    // Write landing in the same cycle as an accept must be visible to that walk.
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = NODE_W'(mk_leaf(77));
    in_valid = 1'b1; feat_in = with_f6(1);
    tab[1] = mk_leaf(77);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b0) begin
      bad++; $display("FAIL idle write cfg_err: got %b want 0", cfg_err);
    end
    wait_out(cyc);
    total++;
    if (class_out !== 8'd77 || cyc != 3) begin
      bad++; $display("FAIL same-cycle write: class=%0d lat=%0d want 77/3", class_out, cyc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    write_node(1, mk_leaf(165));
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; feat_in = with_f6(2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || class_out !== 8'd0) begin
      bad++; $display("FAIL mid reset: out_valid=%b in_ready=%b class=%0d want 0/1/0", out_valid, in_ready, class_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_walk(with_f6(3), 25, "post_reset");
    run_walk(with_f6(0), 165, "post_reset2");
  endtask

  // Right pointers always move forward, so every random table is acyclic.
  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 16; a++) begin
        if (a == 15 || $urandom_range(0, 2) == 0)
          write_node(a, mk_leaf($urandom_range(0, 255)));
        else
          write_node(a, mk_int($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(a + 1, 15)));
      end
      for (int v = 0; v < 8; v++) run_walk(rand_feat(), -1, "random");
    end
  endtask

  task automatic test_depth_guard();
    logic [N_FEAT*FEAT_W-1:0] f = rand_feat();
    f[FEAT_W-1:0] = 6'd1;
    write_node(0, 0);
    if (GUARD) begin
      run_walk(f, 0, "guard");
    end else begin
      bit seen = 1'b0;
      in_valid = 1'b1; feat_in = f;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen || in_ready !== 1'b0) begin
        bad++; $display("FAIL cyclic hang: seen_valid=%b in_ready=%b want 0/0", seen, in_ready);
      end
      do_reset();
    end
  endtask

  initial begin
    cfg_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_small_tree();
    test_backpressure();
    test_cfg_busy();
    test_reset_mid();
    test_random();
    test_depth_guard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
